// File: rtl/pu_types.sv
// Shared load-unit types: field size encoding and its byte count.
package pu_types;

  typedef enum logic [1:0] {
    ext_byte  = 2'd0,
    ext_half  = 2'd1,
    ext_word  = 2'd2,
    ext_dword = 2'd3
  } ext_size_e;

  // Number of bytes covered by a field of the given size.
  function automatic int ext_bytes(input ext_size_e size);
    case (size)
      ext_byte:  return 1;
      ext_half:  return 2;
      ext_word:  return 4;
      default:   return 8;
    endcase
  endfunction

endpackage

// File: rtl/ext_align_stage.sv
// One pipeline slot: holds a payload with a valid flag and accepts a new
// beat whenever it is empty or its current beat leaves in the same cycle.
module ext_align_stage #(
  parameter type payload_t = logic
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_payload,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_payload
);

  logic     valid_reg;
  payload_t payload_reg;

  assign in_ready    = !valid_reg || out_ready;
  assign out_valid   = valid_reg;
  assign out_payload = payload_reg;

  // Slot register: load on transfer, clear valid when drained, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      payload_reg <= '0;
    end else if (in_valid && in_ready) begin
      valid_reg   <= 1'b1;
      payload_reg <= in_payload;
    end else if (out_ready) begin
      valid_reg   <= 1'b0;
    end
  end

endmodule

// File: rtl/ext_align_pipe.sv
// Two-stage load-data extractor/extender. Stage 1 right-justifies the
// addressed big-endian field, stage 2 optionally byte-reverses it and
// zero/sign-extends it to the full word.
// Optional load-byte-reverse support: define EXT_ALIGN_PIPE_BYTE_REVERSE_EN.
module ext_align_pipe
  import pu_types::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]      in_offset,
  input  logic [1:0]                           in_size,
  input  logic                                 in_sign,
`ifdef EXT_ALIGN_PIPE_BYTE_REVERSE_EN
  input  logic                                 in_brev,
`endif
  input  logic [TAG_WIDTH-1:0]                 in_tag,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [TAG_WIDTH-1:0]                 out_tag,
  output logic                                 out_misalign
);

  localparam int NB = DATA_WIDTH / 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] field;
    ext_size_e             size;
    logic                  sign;
    logic                  brev;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  misalign;
  } s1_payload_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  misalign;
  } s2_payload_t;

  s1_payload_t s1_d, s1_q;
  s2_payload_t s2_d, s2_q;
  logic        s1_valid, s2_ready;
  logic        brev_in;

`ifdef EXT_ALIGN_PIPE_BYTE_REVERSE_EN
  assign brev_in = in_brev;
`else
  assign brev_in = 1'b0;
`endif

  // Align: shift the field so its last byte lands in bits [7:0]; flag fields
  // running past the word end (and doublewords on a 32-bit word).
  int        in_nbytes;
  int        in_shift;
  ext_size_e in_size_e;
  always_comb begin
    in_size_e     = ext_size_e'(in_size);
    in_nbytes     = ext_bytes(in_size_e);
    in_shift      = NB - int'(in_offset) - in_nbytes;
    s1_d          = '0;
    s1_d.size     = in_size_e;
    s1_d.sign     = in_sign;
    s1_d.brev     = brev_in;
    s1_d.tag      = in_tag;
    s1_d.misalign = (in_shift < 0) || ((in_size_e == ext_dword) && (DATA_WIDTH == 32));
    if (!s1_d.misalign) begin
      s1_d.field = in_data >> (8 * in_shift);
    end
  end

  ext_align_stage #(.payload_t(s1_payload_t)) u_stage1 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (s1_d),
    .out_valid   (s1_valid),
    .out_ready   (s2_ready),
    .out_payload (s1_q)
  );

  // Extend: reverse the field bytes if requested, then pick the fill bit from
  // the (possibly reversed) field MSB.
  int                    fld_nbytes;
  int                    fld_bits;
  logic [DATA_WIDTH-1:0] rev_field;
  logic                  fld_msb;
  logic                  fill;
  always_comb begin
    fld_nbytes = ext_bytes(s1_q.size);
    fld_bits   = (fld_nbytes * 8 > DATA_WIDTH) ? DATA_WIDTH : fld_nbytes * 8;
    rev_field  = s1_q.field;
    if (s1_q.brev && (fld_nbytes > 1)) begin
      rev_field = '0;
      for (int k = 0; k < NB; k++) begin
        for (int j = 0; j < NB; j++) begin
          if ((k < fld_nbytes) && (j == fld_nbytes - 1 - k)) begin
            rev_field[k*8 +: 8] = s1_q.field[j*8 +: 8];
          end
        end
      end
    end
    fld_msb = 1'b0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      if (b == fld_bits - 1) begin
        fld_msb = rev_field[b];
      end
    end
    fill = s1_q.sign && fld_msb;
  end

  logic [DATA_WIDTH-1:0] ext_data;
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_ext
      assign ext_data[gi] = s1_q.misalign ? 1'b0 : ((gi < fld_bits) ? rev_field[gi] : fill);
    end
  endgenerate

  assign s2_d.data     = ext_data;
  assign s2_d.tag      = s1_q.tag;
  assign s2_d.misalign = s1_q.misalign;

  ext_align_stage #(.payload_t(s2_payload_t)) u_stage2 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (s1_valid),
    .in_ready    (s2_ready),
    .in_payload  (s2_d),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (s2_q)
  );

  assign out_data     = s2_q.data;
  assign out_tag      = s2_q.tag;
  assign out_misalign = s2_q.misalign;

endmodule

// File: tb/tb_ext_align_pipe.sv
// Directed bench for ext_align_pipe (DATA_WIDTH=32): single beats with
// hand-computed results, a stalled stream, and reset flush.
module tb_ext_align_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_offset;
  logic [1:0]  in_size;
  logic        in_sign;
`ifdef EXT_ALIGN_PIPE_BYTE_REVERSE_EN
  logic        in_brev;
`endif
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_misalign;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ext_align_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_offset    (in_offset),
    .in_size      (in_size),
    .in_sign      (in_sign),
`ifdef EXT_ALIGN_PIPE_BYTE_REVERSE_EN
    .in_brev      (in_brev),
`endif
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .out_misalign (out_misalign)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One beat through an idle pipe with out_ready held high.
  task automatic run_one(input string name, input logic [31:0] d, input logic [1:0] off,
                         input logic [1:0] sz, input logic sg, input logic br,
                         input logic [4:0] tg, input logic [31:0] exp_d, input logic exp_m);
    int lat;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_offset = off; in_size = sz; in_sign = sg;
    in_tag = tg; out_ready = 1'b1;
`ifdef EXT_ALIGN_PIPE_BYTE_REVERSE_EN
    in_brev = br;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({name, "_seen"}, 64'(seen), 64'd1);
    check({name, "_lat"}, 64'(lat), 64'd2);
    check({name, "_data"}, 64'(out_data), 64'(exp_d));
    check({name, "_mis"}, 64'(out_misalign), 64'(exp_m));
    check({name, "_tag"}, 64'(out_tag), 64'(tg));
    $display("txn %s data=%h off=%0d size=%0d sign=%0d brev=%0d tag=%0d -> out=%h mis=%0d tag=%0d",
             name, d, off, sz, sg, br, tg, out_data, out_misalign, out_tag);
  endtask

  logic [7:0] stream_byte [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int sent, rcvd, occ;
    bit stalled, any_valid, acc_in, acc_out;
    logic [31:0] prev_d;
    logic [4:0]  prev_t;
    logic        prev_m;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_offset = '0; in_size = '0;
    in_sign = 1'b0; in_tag = '0; out_ready = 1'b0;
`ifdef EXT_ALIGN_PIPE_BYTE_REVERSE_EN
    in_brev = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_mis", 64'(out_misalign), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_one("b_off1_s",  32'h8899AABB, 2'd1, 2'd0, 1'b1, 1'b0, 5'd1,  32'hFFFFFF99, 1'b0);
    run_one("h_off2_z",  32'h8899AABB, 2'd2, 2'd1, 1'b0, 1'b0, 5'd2,  32'h0000AABB, 1'b0);
    run_one("h_off2_s",  32'h8899AABB, 2'd2, 2'd1, 1'b1, 1'b0, 5'd3,  32'hFFFFAABB, 1'b0);
    run_one("h_off3_mis",32'h8899AABB, 2'd3, 2'd1, 1'b1, 1'b0, 5'd4,  32'h00000000, 1'b1);
    run_one("d_mis",     32'h8899AABB, 2'd0, 2'd3, 1'b0, 1'b0, 5'd5,  32'h00000000, 1'b1);
    run_one("w_pass",    32'h8899AABB, 2'd0, 2'd2, 1'b1, 1'b0, 5'd6,  32'h8899AABB, 1'b0);
    run_one("b_off0_z",  32'h8899AABB, 2'd0, 2'd0, 1'b0, 1'b0, 5'd7,  32'h00000088, 1'b0);
    run_one("b_off3_s",  32'h8899AABB, 2'd3, 2'd0, 1'b1, 1'b0, 5'd8,  32'hFFFFFFBB, 1'b0);
    run_one("w_off1_mis",32'h8899AABB, 2'd1, 2'd2, 1'b0, 1'b0, 5'd9,  32'h00000000, 1'b1);
    run_one("h_off0_s",  32'h8899AABB, 2'd0, 2'd1, 1'b1, 1'b0, 5'd10, 32'hFFFF8899, 1'b0);
    run_one("b_pos_s",   32'h12345678, 2'd2, 2'd0, 1'b1, 1'b0, 5'd11, 32'h00000056, 1'b0);
`ifdef EXT_ALIGN_PIPE_BYTE_REVERSE_EN
    run_one("brev_h_s",  32'h8899AABB, 2'd0, 2'd1, 1'b1, 1'b1, 5'd12, 32'hFFFF9988, 1'b0);
    run_one("brev_w",    32'h8899AABB, 2'd0, 2'd2, 1'b1, 1'b1, 5'd13, 32'hBBAA9988, 1'b0);
    run_one("brev_b",    32'h8899AABB, 2'd1, 2'd0, 1'b1, 1'b1, 5'd14, 32'hFFFFFF99, 1'b0);
`endif

    // Stream of 8 byte loads with out_ready pattern 1,0,0,1,0,0,...
    sent = 0; rcvd = 0; occ = 0; stalled = 1'b0;
    prev_d = '0; prev_t = '0; prev_m = 1'b0;
    for (int c = 0; c < 80 && rcvd < 8; c++) begin
      @(negedge clk);
      out_ready = (c % 3 == 0);
      in_valid  = (sent < 8);
      in_data   = 32'h11223344;
      in_offset = 2'(sent);
      in_size   = 2'd0;
      in_sign   = 1'b0;
      in_tag    = 5'(sent);
      #1;
      check("str_in_ready", 64'(in_ready), 64'(!(occ == 2 && !out_ready)));
      if (stalled) begin
        check("str_hold_valid", 64'(out_valid), 64'd1);
        check("str_hold_data", 64'(out_data), 64'(prev_d));
        check("str_hold_tag", 64'(out_tag), 64'(prev_t));
        check("str_hold_mis", 64'(out_misalign), 64'(prev_m));
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        check("str_tag", 64'(out_tag), 64'(rcvd));
        check("str_data", 64'(out_data), 64'(stream_byte[rcvd % 4]));
        $display("txn stream tag=%0d data=%h cycle=%0d", out_tag, out_data, c);
        rcvd++;
      end
      stalled = out_valid && !out_ready;
      prev_d = out_data; prev_t = out_tag; prev_m = out_misalign;
      if (acc_in) sent++;
      occ = occ + int'(acc_in) - int'(acc_out);
    end
    check("str_count", 64'(rcvd), 64'd8);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h8899AABB; in_offset = 2'd0; in_size = 2'd2;
    in_sign = 1'b0; in_tag = 5'd20;
    @(negedge clk);
    in_tag = 5'd21;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_data", 64'(out_data), 64'd0);
    check("flush_tag", 64'(out_tag), 64'd0);
    check("flush_mis", 64'(out_misalign), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    any_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_valid = any_valid | out_valid;
    end
    check("flush_no_stale", 64'(any_valid), 64'd0);
    $display("txn flush tags=20,21 dropped out_valid_seen=%0d", any_valid);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
